// File: rtl/crc_mem_arbiter_if.sv
// crc_mem_arbiter_if: Avalon-MM master port bundle between one master and the arbiter
interface crc_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              lock;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/crc_mem_arbiter.sv
// crc_mem_arbiter: two-master round-robin/lock arbiter for the single-port CRC RAM (option: CRC_MEM_ARB_FIXED_PRIO_EN gives master 0 fixed priority)
module crc_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  crc_mem_arbiter_if.slave  m0,
  crc_mem_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              ram_clken
);
  logic       req0, req1, force_rel, lock_hold, pick1, rr_pick;
  logic       gnt0, gnt1, any_gnt, sel, wr_sel, rd_acc;
  logic       last_grant, acc_last, rd_pending, rd_owner;
  logic [3:0] hold_cnt;
`ifdef CRC_MEM_ARB_FIXED_PRIO_EN
  assign rr_pick = 1'b0;
`else
  assign rr_pick = ~last_grant;
`endif
  // Grant selection: lock hold, then 16-run force release, then round-robin / priority
  always_comb begin
    req0      = m0.read | m0.write;
    req1      = m1.read | m1.write;
    force_rel = hold_cnt == 4'hf;
    lock_hold = acc_last & ~force_rel & (last_grant ? (req1 & m1.lock) : (req0 & m0.lock));
    pick1     = lock_hold ? last_grant : force_rel ? ~last_grant : rr_pick;
    gnt1      = reset_n & req1 & (~req0 | pick1);
    gnt0      = reset_n & req0 & ~gnt1;
    any_gnt   = gnt0 | gnt1;
    sel       = gnt1;
    wr_sel    = sel ? m1.write : m0.write;
    rd_acc    = any_gnt & ~wr_sel;
  end
  // RAM port steered from the granted master; reads always use all byte lanes
  always_comb begin
    ram_address    = sel ? m1.address : m0.address;
    ram_writedata  = sel ? m1.writedata : m0.writedata;
    ram_byteenable = wr_sel ? (sel ? m1.byteenable : m0.byteenable) : '1;
    ram_chipselect = any_gnt;
    ram_write      = any_gnt & wr_sel;
    ram_clken      = 1'b1;
  end
  // Master-side responses; read data bus is shared, only the owner sees valid
  always_comb begin
    m0.waitrequest   = ~gnt0;
    m1.waitrequest   = ~gnt1;
    m0.readdata      = ram_readdata;
    m1.readdata      = ram_readdata;
    m0.readdatavalid = reset_n & rd_pending & ~rd_owner;
    m1.readdatavalid = reset_n & rd_pending & rd_owner;
  end
  // Arbitration history, hold counter and read-return tracking
  always_ff @(posedge clk)
    if (!reset_n) begin
      last_grant <= 1'b1;
      acc_last   <= 1'b0;
      hold_cnt   <= 4'd0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      acc_last   <= any_gnt;
      rd_pending <= rd_acc;
      if (rd_acc) rd_owner <= sel;
      if (any_gnt) last_grant <= sel;
      hold_cnt   <= (any_gnt & acc_last & (sel == last_grant)) ? hold_cnt + 4'd1 : 4'd0;
    end
endmodule
